// File: rtl/dsram_resp_pkg.sv
// Shared constants and helpers for the dsram_resp data-port responder.
// This file holds the MMIO map, the legal byte-enable set and the byte-merge helper.
package dsram_resp_pkg;

    localparam logic [15:0] MMIO_HI    = 16'hBFAF;
    localparam logic [15:0] LED_OFF    = 16'hF000;
    localparam logic [15:0] NUM_OFF    = 16'hF010;
    localparam logic [15:0] SWITCH_OFF = 16'hF020;
    localparam logic [15:0] TIMER_OFF  = 16'hE000;

    // Byte, halfword and word enables the core may legally issue.
    localparam logic [31:0] LEGAL_WEN_LIST = {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                              4'b1000, 4'b0011, 4'b1100, 4'b1111};

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_LED   = 3'd1,
        SEL_NUM   = 3'd2,
        SEL_SW    = 3'd3,
        SEL_TIMER = 3'd4
    } mmio_sel_e;

    function automatic logic wen_legal(input logic [3:0] wen);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (LEGAL_WEN_LIST[4*i +: 4] == wen) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_resp_if.sv
// Data-SRAM request/response bus between the core (master) and a responder (slave).
interface dsram_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/dsram_resp_bram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port,
// written in the read-first template so synthesis maps it to block RAM.
module bram_be #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // Byte-lane writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Registered read; the output holds when no read is requested.
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/dsram_resp.sv
// Responder for the core's data-SRAM port: local byte-writable RAM plus LED/NUM/SWITCH/TIMER MMIO.
// Optional sticky bus-error flag on err_o when DSRAM_RESP_BUSERR_EN is defined.
module dsram_resp #(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] MMIO_HI = dsram_resp_pkg::MMIO_HI,
    parameter int          TIMER_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    dsram_resp_if.slave  bus,
    input  logic [15:0]  switch_i,
    output logic [15:0]  led_o,
    output logic [31:0]  num_o
`ifdef DSRAM_RESP_BUSERR_EN
    ,
    output logic         err_o
`endif
);

    import dsram_resp_pkg::*;

    logic               w_is_mmio;
    logic               w_rd;
    logic               w_wr;
    mmio_sel_e          w_sel;
    logic [31:0]        w_mmio_rdata;
    logic [15:0]        w_led_merged;
    logic [31:0]        w_num_merged;
    logic [31:0]        w_timer_merged;
    logic [3:0]         w_ram_we;
    logic               w_ram_re;
    logic [31:0]        w_ram_q;

    logic [15:0]        r_led;
    logic [31:0]        r_num;
    logic [TIMER_W-1:0] r_timer;
    logic               r_rd_ram;
    logic [31:0]        r_mmio_rdata;

    assign w_is_mmio = (bus.addr[31:16] == MMIO_HI);
    assign w_rd      = bus.en && (bus.wen == 4'b0000);
    assign w_wr      = bus.en && (bus.wen != 4'b0000);

    // MMIO offset decode.
    always_comb begin
        w_sel = SEL_NONE;
        if (w_is_mmio) begin
            case (bus.addr[15:0])
                LED_OFF:    w_sel = SEL_LED;
                NUM_OFF:    w_sel = SEL_NUM;
                SWITCH_OFF: w_sel = SEL_SW;
                TIMER_OFF:  w_sel = SEL_TIMER;
                default:    w_sel = SEL_NONE;
            endcase
        end else begin
            w_sel = SEL_NONE;
        end
    end

    // MMIO read data from the state held in the request cycle.
    always_comb begin
        w_mmio_rdata = 32'h0000_0000;
        case (w_sel)
            SEL_LED:   w_mmio_rdata = {16'h0000, r_led};
            SEL_NUM:   w_mmio_rdata = r_num;
            SEL_SW:    w_mmio_rdata = {16'h0000, switch_i};
            SEL_TIMER: w_mmio_rdata = r_timer;
            default:   w_mmio_rdata = 32'h0000_0000;
        endcase
    end

    assign w_led_merged   = {bus.wen[1] ? bus.wdata[15:8] : r_led[15:8],
                             bus.wen[0] ? bus.wdata[7:0]  : r_led[7:0]};
    assign w_num_merged   = byte_merge(r_num, bus.wdata, bus.wen);
    assign w_timer_merged = byte_merge(r_timer, bus.wdata, bus.wen);

    // A request seen while rst is high must not reach the RAM.
    assign w_ram_we = (w_wr && !w_is_mmio && !rst) ? bus.wen : 4'b0000;
    assign w_ram_re = w_rd && !w_is_mmio && !rst;

    bram_be #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (bus.addr[ADDR_W+1:2]),
        .i_wdata (bus.wdata),
        .o_rdata (w_ram_q)
    );

    // MMIO registers, timer and the read-source tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led        <= 16'h0000;
            r_num        <= 32'h0000_0000;
            r_timer      <= '0;
            r_rd_ram     <= 1'b0;
            r_mmio_rdata <= 32'h0000_0000;
        end else begin
            if (w_wr && (w_sel == SEL_LED)) begin
                r_led <= w_led_merged;
            end
            if (w_wr && (w_sel == SEL_NUM)) begin
                r_num <= w_num_merged;
            end
            if (w_wr && (w_sel == SEL_TIMER)) begin
                r_timer <= w_timer_merged;
            end else begin
                r_timer <= r_timer + {{(TIMER_W-1){1'b0}}, 1'b1};
            end
            if (w_rd) begin
                r_rd_ram     <= !w_is_mmio;
                r_mmio_rdata <= w_mmio_rdata;
            end
        end
    end

    // Both sources are registers; the select only changes on a read.
    assign bus.rdata = r_rd_ram ? w_ram_q : r_mmio_rdata;
    assign led_o     = r_led;
    assign num_o     = r_num;

`ifdef DSRAM_RESP_BUSERR_EN
    logic r_err;
    logic w_bad;

    assign w_bad = bus.en && (!wen_legal(bus.wen) ||
                              (w_is_mmio && (w_sel == SEL_NONE)) ||
                              (w_wr && (w_sel == SEL_SW)));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_dsram_resp.sv
// Scoreboard bench for dsram_resp: expected read data is queued at issue and checked one cycle later.
module tb_dsram_resp;

    logic        clk;
    logic        rst;
    logic [15:0] switch_i;
    logic [15:0] led_o;
    logic [31:0] num_o;
`ifdef DSRAM_RESP_BUSERR_EN
    logic        err_o;
`endif

    dsram_resp_if bus ();

    dsram_resp dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .switch_i (switch_i),
        .led_o    (led_o),
        .num_o    (num_o)
`ifdef DSRAM_RESP_BUSERR_EN
        ,
        .err_o    (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle; when chk is set the expected rdata is queued and checked after the edge.
    task automatic issue(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input bit chk, input string tag,
                         input logic [31:0] expv);
        exp_t x;
        bus.en    = e;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
        if (chk) sb_q.push_back('{tag, expv});
        @(posedge clk);
        #1;
        bus.en  = 1'b0;
        bus.wen = 4'b0000;
        if (chk) begin
            if (sb_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'h0000_0001, 32'h0000_0000);
            end else begin
                x = sb_q.pop_front();
                check_eq(x.tag, bus.rdata, x.val);
            end
        end
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] expv);
        issue(1'b1, 4'b0000, a, 32'h0000_0000, 1'b1, tag, expv);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        issue(1'b1, w, a, d, 1'b0, "", 32'h0000_0000);
    endtask

    task automatic idle();
        issue(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, "", 32'h0000_0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  w;
        int          k;

        rst       = 1'b1;
        switch_i  = 16'h0000;
        bus.en    = 1'b0;
        bus.wen   = 4'b0000;
        bus.addr  = 32'h0000_0000;
        bus.wdata = 32'h0000_0000;

        do_reset();
        check_eq("rst_rdata", bus.rdata, 32'h0000_0000);
        check_eq("rst_led", {16'h0000, led_o}, 32'h0000_0000);
        check_eq("rst_num", num_o, 32'h0000_0000);

        // Now in cycle 0 after reset; the timer read in cycle 10 returns 10.
        for (int i = 0; i < 10; i++) idle();
        rd(32'hBFAF_E000, "timer_c10", 32'h0000_000A);

        wr(32'h0000_0010, 4'b1111, 32'h1122_3344);
        wr(32'h0000_0010, 4'b0010, 32'h0000_AA00);
        rd(32'h0000_0010, "ram_lanes", 32'h1122_AA44);
        issue(1'b1, 4'b1111, 32'h0000_0014, 32'h5555_5555, 1'b1, "hold_wr", 32'h1122_AA44);
        issue(1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0000, 1'b1, "hold_idle", 32'h1122_AA44);

        wr(32'h0000_0000, 4'b1111, 32'hDEAD_BEEF);
        rd(32'h0001_0000, "alias", 32'hDEAD_BEEF);

        wr(32'hBFAF_F000, 4'b1111, 32'h0000_5A5A);
        check_eq("led_o", {16'h0000, led_o}, 32'h0000_5A5A);
        rd(32'hBFAF_F000, "led_rd", 32'h0000_5A5A);

        wr(32'hBFAF_F010, 4'b1111, 32'h1111_1111);
        wr(32'hBFAF_F010, 4'b1000, 32'hAB00_0000);
        check_eq("num_o", num_o, 32'hAB11_1111);
        rd(32'hBFAF_F010, "num_rd", 32'hAB11_1111);

        switch_i = 16'h00F0;
        rd(32'hBFAF_F020, "switch", 32'h0000_00F0);
        rd(32'hBFAF_F030, "unmapped", 32'h0000_0000);

        wr(32'hBFAF_E000, 4'b1111, 32'hFFFF_FFFE);
        idle();
        rd(32'hBFAF_E000, "timer_max", 32'hFFFF_FFFF);
        rd(32'hBFAF_E000, "timer_wrap", 32'h0000_0000);

        // Reset arriving together with a write: the write is dropped.
        wr(32'h0000_0020, 4'b1111, 32'hCAFE_F00D);
        rd(32'h0000_0020, "pre_rst", 32'hCAFE_F00D);
        rst = 1'b1;
        wr(32'h0000_0020, 4'b1111, 32'h1234_5678);
        rst = 1'b0;
        check_eq("midrst_rdata", bus.rdata, 32'h0000_0000);
        check_eq("midrst_led", {16'h0000, led_o}, 32'h0000_0000);
        check_eq("midrst_num", num_o, 32'h0000_0000);
        rd(32'hBFAF_E000, "timer_after_rst", 32'h0000_0000);
        rd(32'h0000_0020, "ram_kept", 32'hCAFE_F00D);

        // Random byte-lane traffic over 8 words against a bench model.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            mdl[i] = d;
            wr(32'h0000_0200 + 32'(4 * i), 4'b1111, d);
        end
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, 7);
            w = 4'($urandom_range(1, 15));
            d = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (w[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
            end
            wr(32'h0000_0200 + 32'(4 * k), w, d);
        end
        for (int i = 0; i < 8; i++) begin
            rd(32'h0000_0200 + 32'(4 * i), $sformatf("rand_w%0d", i), mdl[i]);
        end

`ifdef DSRAM_RESP_BUSERR_EN
        do_reset();
        check_eq("err_rst", {31'd0, err_o}, 32'h0000_0000);
        rd(32'hBFAF_F000, "err_legal_rd", 32'h0000_0000);
        wr(32'h0000_0030, 4'b0011, 32'h0000_BEEF);
        check_eq("err_legal", {31'd0, err_o}, 32'h0000_0000);
        wr(32'hBFAF_F020, 4'b1111, 32'h0000_FFFF);
        check_eq("err_sw_wr", {31'd0, err_o}, 32'h0000_0001);
        idle();
        idle();
        check_eq("err_sticky", {31'd0, err_o}, 32'h0000_0001);
        rd(32'hBFAF_F020, "err_sw_kept", 32'h0000_00F0);
        do_reset();
        check_eq("err_clr", {31'd0, err_o}, 32'h0000_0000);
        wr(32'h0000_0040, 4'b0101, 32'h00AA_00BB);
        check_eq("err_bad_wen", {31'd0, err_o}, 32'h0000_0001);
        do_reset();
        rd(32'hBFAF_F040, "err_unmap_rd", 32'h0000_0000);
        check_eq("err_unmap", {31'd0, err_o}, 32'h0000_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
